reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 107 ++++++++++
 tb/tb_reg_dump.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file dump engine: stalls the CPU, walks registers first..last through the
// debug read port and streams each one out as a valid/ready beat with a running checksum.
module reg_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] dbg_raddr,
    input  logic [DATA_W-1:0] dbg_rdata,
    output logic              cpu_stall,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last;

    assign dbg_raddr = cur;
    assign fsm_state = state;

    // dump_valid/dump_ready: a beat transfers on any rising edge where both are high;
    // dump_addr/dump_data/dump_last are held unchanged from the rise of dump_valid
    // until that transfer, and dump_valid never drops without a transfer (except reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            last       <= '0;
            cpu_stall  <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last     <= last_reg;
                        cur      <= first_reg;
                        checksum <= '0;
                        busy     <= 1'b1;
                        // An inverted range produces no beats, only the done pulse.
                        if (first_reg > last_reg) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= READ;
                            cpu_stall <= 1'b1;
                        end
                    end
                end
                READ: begin
                    dump_data  <= dbg_rdata;
                    dump_addr  <= cur;
                    dump_last  <= (cur == last);
                    dump_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        checksum   <= checksum + dump_data;
                        // Stopping on dump_last rather than on cur overflow avoids wrap at the top index.
                        if (dump_last) begin
                            dump_last <= 1'b0;
                            cpu_stall <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cur   <= cur + ADDR_W'(1);
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a table of dump scenarios with hand-computed results,
// plus hand-written reset-abort and reset-versus-start sequences.
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic        cpu_stall;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic [1:0]  fsm_state;

    logic [31:0] rf [32];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  first;
        logic [4:0]  last;
        bit          toggle;
        bit          poke;
        int          exp_beats;
        logic [31:0] exp_sum;
        int          exp_stall;
        int          exp_first_valid;
        int          exp_done_at;
    } vec_t;

    vec_t vecs [8];

    reg_dump #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_reg  (first_reg),
        .last_reg   (last_reg),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .cpu_stall  (cpu_stall),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    assign dbg_rdata = rf[dbg_raddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, dump_valid, 0);
        check({tag, "_last"}, dump_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_stall"}, cpu_stall, 0);
        check({tag, "_addr"}, dump_addr, 0);
        check({tag, "_data"}, dump_data, 0);
        check({tag, "_checksum"}, checksum, 0);
        check({tag, "_raddr"}, dbg_raddr, 0);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    task automatic run_dump(input vec_t v);
        int beats, stall, first_valid, done_at, done_cnt, hold;
        logic [4:0]  exp_addr, h_addr;
        logic [31:0] h_data, exp_d;
        logic        h_last;
        beats = 0; stall = 0; first_valid = -1; done_at = -1; done_cnt = 0; hold = 0;
        h_addr = '0; h_data = '0; h_last = 1'b0;
        exp_q.delete();
        for (int i = int'(v.first); i <= int'(v.last); i++) exp_q.push_back(rf[i]);
        exp_addr = v.first;
        @(negedge clk);
        first_reg = v.first;
        last_reg  = v.last;
        start     = 1'b1;
        dump_ready = !v.toggle;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (cpu_stall) stall++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (dump_valid) begin
                if (first_valid < 0) first_valid = n;
                if (hold == 0) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        exp_d = exp_q.pop_front();
                        check("beat_addr", dump_addr, exp_addr);
                        check("beat_data", dump_data, exp_d);
                        check("beat_last", dump_last, exp_addr == v.last);
                    end
                    h_addr = dump_addr; h_data = dump_data; h_last = dump_last;
                end else begin
                    check("hold_addr", dump_addr, h_addr);
                    check("hold_data", dump_data, h_data);
                    check("hold_last", dump_last, h_last);
                end
                if (v.poke && hold == 0 && beats == 0) begin
                    start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
                end else begin
                    start = 1'b0; first_reg = v.first; last_reg = v.last;
                end
                dump_ready = v.toggle ? (hold == 2) : 1'b1;
                if (dump_ready) begin
                    beats++; hold = 0; exp_addr = exp_addr + 5'd1;
                end else begin
                    hold++;
                end
            end else begin
                start = 1'b0;
                dump_ready = !v.toggle;
            end
            if (done_at >= 0 && n > done_at) break;
            @(negedge clk);
        end
        if (done_at < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_count", done_cnt, 1);
            check("done_at", done_at, v.exp_done_at);
            check("idle_busy", busy, 0);
            check("idle_state", fsm_state, 0);
            check("beats", beats, v.exp_beats);
            check("checksum", checksum, v.exp_sum);
            check("stall_cycles", stall, v.exp_stall);
            check("first_valid", first_valid, v.exp_first_valid);
            check("scoreboard_empty", exp_q.size(), 0);
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(2 * i + 3);
        rf[13] = 32'hFFFF_FFFF;

        //         first  last   tgl  poke beats sum            stall fv  done
        vecs[0] = '{5'd1,  5'd3,  0,   0,   3,    32'd21,        6,    1,  6};
        vecs[1] = '{5'd1,  5'd3,  1,   0,   3,    32'd21,        12,   1,  12};
        vecs[2] = '{5'd4,  5'd2,  0,   0,   0,    32'd0,         0,    -1, 0};
        vecs[3] = '{5'd13, 5'd13, 0,   0,   1,    32'hFFFF_FFFF, 2,    1,  2};
        vecs[4] = '{5'd0,  5'd1,  0,   0,   2,    32'd8,         4,    1,  4};
        vecs[5] = '{5'd30, 5'd31, 0,   0,   2,    32'd128,       4,    1,  4};
        vecs[6] = '{5'd5,  5'd5,  1,   0,   1,    32'd13,        4,    1,  4};
        vecs[7] = '{5'd1,  5'd3,  0,   1,   3,    32'd21,        6,    1,  6};

        reset = 1'b1; start = 1'b0; dump_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_dump(vecs[i]);

        // Abort a 1..13 dump in its third SEND, with start also high during reset.
        @(negedge clk);
        first_reg = 5'd1; last_reg = 5'd13; start = 1'b1; dump_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pre_valid", dump_valid, 1);
        check("abort_pre_addr", dump_addr, 3);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);

        run_dump(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
